// File: rtl/act_quant_pkg.sv
// act_quant shared widths, word types and small arithmetic helpers.
// Rounding is selected by the ACT_QUANT_ROUND_EN macro, which is evaluated in rshift_sat.
package act_quant_pkg;

  localparam int ACC_W   = 24;
  localparam int BIAS_W  = 16;
  localparam int SHIFT_W = 5;
  localparam int OUT_W   = 8;
  localparam int CNT_W   = 16;
  localparam int SUM_W   = 26;
  localparam int RELU_W  = SUM_W - 1;
  localparam int OUT_MAX = 255;

  typedef logic signed [SUM_W-1:0] sum_t;
  typedef logic [RELU_W-1:0]       relu_t;
  typedef logic [OUT_W-1:0]        out_t;
  typedef logic [SHIFT_W-1:0]      shift_t;
  typedef logic [CNT_W-1:0]        cnt_t;

  function automatic sum_t bias_add(input logic [ACC_W-1:0] acc,
                                    input logic signed [BIAS_W-1:0] bias);
    sum_t acc_ext;
    sum_t bias_ext;
    acc_ext  = $signed({{(SUM_W-ACC_W){1'b0}}, acc});
    bias_ext = $signed({{(SUM_W-BIAS_W){bias[BIAS_W-1]}}, bias});
    return acc_ext + bias_ext;
  endfunction

  function automatic relu_t relu(input sum_t s);
    if (s[SUM_W-1]) begin
      return '0;
    end else begin
      return s[RELU_W-1:0];
    end
  endfunction

  // Saturating increment: the counter sticks at all-ones.
  function automatic cnt_t sat_inc(input cnt_t c);
    if (&c) begin
      return c;
    end else begin
      return c + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/act_quant_rshift_sat.sv
// rshift_sat: combinational stage-2 datapath, ReLU value -> shifted, clamped activation.
// Macro ACT_QUANT_ROUND_EN selects round-half-up; undefined means truncation.
module rshift_sat
  import act_quant_pkg::*;
(
  input  logic [RELU_W-1:0]  r,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   out_data,
  output logic               sat_flag
);

  // Wide enough that r + 2^30 can never overflow before the shift.
  localparam int EXT_W = 33;

  logic [EXT_W-1:0] ext_s;
  logic [EXT_W-1:0] rnd_s;
  logic [EXT_W-1:0] q_s;

  // Rounding term for the current shift amount.
  always_comb begin
`ifdef ACT_QUANT_ROUND_EN
    if (shift != '0) begin
      rnd_s = {{(EXT_W-1){1'b0}}, 1'b1} << (shift - shift_t'(1));
    end else begin
      rnd_s = '0;
    end
`else
    rnd_s = '0;
`endif
  end

  // Shift and clamp to the unsigned output range.
  always_comb begin
    ext_s    = {{(EXT_W-RELU_W){1'b0}}, r};
    q_s      = (ext_s + rnd_s) >> shift;
    sat_flag = |q_s[EXT_W-1:OUT_W];
    if (sat_flag) begin
      out_data = out_t'(OUT_MAX);
    end else begin
      out_data = q_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/act_quant.sv
// act_quant: 2-stage bias/ReLU/shift/saturate output stage with valid/ready on both sides.
// Build with ACT_QUANT_ROUND_EN defined for round-half-up, otherwise truncation.
module act_quant
  import act_quant_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ACC_W-1:0]         in_acc,
  input  logic signed [BIAS_W-1:0] in_bias,
  input  logic [SHIFT_W-1:0]       in_shift,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  input  logic                     clr_stats,
  output logic [CNT_W-1:0]         sat_count
);

  logic   s1_valid_r;
  sum_t   sum_r;
  shift_t shift_r;
  logic   out_valid_r;
  out_t   out_data_r;
  logic   sat_r;
  cnt_t   cnt_r;

  logic   adv1_s;
  logic   adv2_s;
  logic   out_xfer_s;
  relu_t  relu_s;
  out_t   q_data_s;
  logic   q_sat_s;

  // Pipeline advance: an empty stage always accepts, so bubbles collapse.
  always_comb begin
    adv2_s     = !out_valid_r || out_ready;
    adv1_s     = !s1_valid_r || adv2_s;
    out_xfer_s = out_valid_r && out_ready;
    relu_s     = relu(sum_r);
  end

  assign in_ready  = adv1_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign sat_count = cnt_r;

  // Stage 1: bias add.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      sum_r      <= '0;
      shift_r    <= '0;
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        sum_r   <= bias_add(in_acc, in_bias);
        shift_r <= in_shift;
      end
    end
  end

  rshift_sat u_rshift_sat (
    .r        (relu_s),
    .shift    (shift_r),
    .out_data (q_data_s),
    .sat_flag (q_sat_s)
  );

  // Stage 2: holds the result stable until downstream takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      sat_r       <= 1'b0;
    end else if (adv2_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_data_r <= q_data_s;
        sat_r      <= q_sat_s;
      end
    end
  end

  // Saturation-event counter; a clear beats a same-edge increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clr_stats) begin
      cnt_r <= '0;
    end else if (out_xfer_s && sat_r) begin
      cnt_r <= sat_inc(cnt_r);
    end
  end

endmodule

// File: tb/tb_act_quant.sv
// Self-checking bench for act_quant: directed cases plus randomized traffic
// against a queue-based arithmetic model (honours ACT_QUANT_ROUND_EN).
module tb_act_quant;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [23:0]        in_acc = 24'd0;
  logic signed [15:0] in_bias = 16'sd0;
  logic [4:0]         in_shift = 5'd0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [7:0]         out_data;
  logic               clr_stats = 1'b0;
  logic [15:0]        sat_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int data;
    bit sat;
  } exp_t;

  exp_t  mq[$];
  int    mcnt = 0;
  bit    held = 1'b0;
  int    held_data = 0;

`ifdef ACT_QUANT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  act_quant dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .in_bias   (in_bias),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .clr_stats (clr_stats),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference arithmetic straight from the quantisation rules.
  function automatic exp_t model(input longint acc, input longint bias, input int sh);
    longint s;
    longint rnd;
    longint qv;
    exp_t   e;
    s   = acc + bias;
    rnd = 0;
    if (s < 0) s = 0;
    if (ROUND && sh > 0) rnd = longint'(1) << (sh - 1);
    qv     = (s + rnd) / (longint'(1) << sh);
    e.sat  = (qv > 255);
    e.data = (qv > 255) ? 255 : int'(qv);
    return e;
  endfunction

  // Compare process: sampled on the falling edge, away from state updates.
  always @(negedge clk) begin
    exp_t e;
    bit   xfer;
    if (!reset) begin
      mq.delete();
      mcnt = 0;
      held = 1'b0;
    end else begin
      e.data = 0;
      e.sat  = 1'b0;
      check("sat_count", longint'(sat_count), longint'(mcnt));
      check("in_ready", longint'(in_ready), longint'((mq.size() < 2) || out_ready));
      if (mq.size() == 0) check("idle_out_valid", longint'(out_valid), 0);
      if (held) begin
        check("hold_valid", longint'(out_valid), 1);
        check("hold_data", longint'(out_data), longint'(held_data));
      end
      xfer = out_valid && out_ready;
      if (xfer) begin
        if (mq.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          e = mq.pop_front();
          check("out_data", longint'(out_data), longint'(e.data));
        end
      end
      if (in_valid && in_ready)
        mq.push_back(model(longint'(in_acc), longint'(in_bias), int'(in_shift)));
      if (clr_stats) mcnt = 0;
      else if (xfer && e.sat && mcnt < 65535) mcnt++;
      held      = out_valid && !out_ready;
      held_data = int'(out_data);
    end
  end

  // Single beat into an empty pipeline with out_ready high; checks 2-cycle latency.
  task automatic beat(input int acc, input int bias, input int sh, input int expv, input string nm);
    in_valid  = 1'b1;
    in_acc    = 24'(acc);
    in_bias   = 16'(bias);
    in_shift  = 5'(sh);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({nm, "_v0"}, longint'(out_valid), 0);
    @(posedge clk); #1;
    check({nm, "_v1"}, longint'(out_valid), 1);
    check({nm, "_data"}, longint'(out_data), longint'(expv));
    @(posedge clk); #1;
    check({nm, "_v2"}, longint'(out_valid), 0);
  endtask

  initial begin
    int   k;
    bit   fire;
    int   got[$];
    exp_t pe;

    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   k;
    bit   fire;
    int   got[$];
    exp_t pe;

    pe = model(24, 0, 4);
    check("model_round24", longint'(pe.data), ROUND ? 2 : 1);
    pe = model(6000, 0, 4);
    check("model_sat", longint'(pe.sat), 1);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_sat_count", longint'(sat_count), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;

    beat(150, 0, 0, 150, "basic");
    check("basic_sat", longint'(sat_count), 0);
    beat(1000, -2000, 0, 0, "relu_neg");
    beat(0, 40, 0, 40, "relu_pos");
    beat(24, 0, 4, ROUND ? 2 : 1, "round24");
    beat(23, 0, 4, 1, "round23");
    beat(6000, 0, 4, 255, "sat");
    check("sat_cnt1", longint'(sat_count), 1);

    in_valid = 1'b1; in_acc = 24'd6000; in_bias = 16'sd0; in_shift = 5'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    check("sat_clr_wins", longint'(sat_count), 0);

    // Backpressure: five beats while output stalls for four cycles.
    out_ready = 1'b0;
    k = 0;
    got.delete();
    for (int c = 0; c < 40 && got.size() < 5; c++) begin
      in_valid = (k < 5);
      in_acc   = 24'(10 + k);
      in_bias  = 16'sd0;
      in_shift = 5'd0;
      if (c == 2) check("bp_ready_c2", longint'(in_ready), 0);
      if (c == 4) begin
        check("bp_ready_c4", longint'(in_ready), 0);
        check("bp_accepts", longint'(k), 2);
        check("bp_hold", longint'(out_data), 10);
        out_ready = 1'b1;
      end
      @(negedge clk);
      fire = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(int'(out_data));
      @(posedge clk); #1;
      if (fire) k++;
    end
    in_valid = 1'b0;
    check("bp_count", longint'(got.size()), 5);
    for (int i = 0; i < got.size(); i++) check("bp_order", longint'(got[i]), longint'(10 + i));

    // Reset with two beats in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_acc = 24'd50;
    @(posedge clk); #1;
    in_acc = 24'd51;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_data", longint'(out_data), 0);
    check("mid_rst_ready", longint'(in_ready), 1);
    @(negedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("no_stale", longint'(out_valid), 0);
    beat(77, 0, 0, 77, "post_rst");

    // Randomized traffic checked by the compare process.
    in_valid = 1'b0;
    fire = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!in_valid || fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_acc   = 24'($urandom_range(0, 24'hFFFFFF) >> $urandom_range(0, 23));
        in_bias  = 16'($urandom);
        in_shift = 5'($urandom_range(0, 31) >> $urandom_range(0, 2));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clr_stats = ($urandom_range(0, 60) == 0);
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    clr_stats = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && mq.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", longint'(mq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/act_quant.md
# act_quant

Output stage that consumes the 24-bit accumulator result of `mac` and produces an 8-bit activation. Per beat: add a signed bias, apply ReLU, right-shift by a per-beat amount (optionally with round-to-nearest), then saturate to 0..255. The result is ready as the next layer's `a` operand. It is a 2-stage pipeline with valid/ready handshakes on both sides and a saturation-event counter for quantisation tuning.

## Interface
- `ACC_W`, 24: accumulator input width; matches `mac.out`.
- `BIAS_W`, 16: signed bias width.
- `SHIFT_W`, 5: shift-amount width (0..31).
- `OUT_W`, 8: unsigned output width.
- `CNT_W`, 16: saturation counter width.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  stage can accept an input beat.
- `in_acc`  in  ACC_W  unsigned accumulator value.
- `in_bias`  in  BIAS_W  signed two's-complement bias.
- `in_shift`  in  SHIFT_W  right-shift amount.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  OUT_W  quantised activation.
- `clr_stats`  in  1  synchronous clear of `sat_count`.
- `sat_count`  out  CNT_W  count of saturated output beats.

## Operation
- Transfer on a side when valid && ready on the same rising edge. A source must not retract `in_valid` or change the input fields until the beat transfers. The block holds `out_valid` and `out_data` stable until the beat transfers.
- Stage 1 computes `sum = zext(in_acc) + sext(in_bias)` as a 26-bit signed value. It registers `sum`, `in_shift` and the s1 valid flag.
- Stage 2 computes:
  - `r = max(sum, 0)`, the ReLU result.
  - `q = floor((r + rnd) / 2^shift)`, evaluated at full width with no intermediate overflow.
  - `out_data = min(q, 255)`.
  - `sat_flag = (q > 255)`, which is registered alongside the data.
- Rounding term: `rnd = 2^(shift-1)` when rounding is compiled in and shift > 0; otherwise `rnd = 0`.
- Flow control, with the whole pipeline advancing together:
  - `adv2 = !out_valid || out_ready`
  - `adv1 = !s1_valid || adv2`
  - `in_ready = adv1`, which is combinational from `out_ready`.
- Bubbles collapse: an empty stage accepts data even while the stage after it is stalled.
- Beats leave in arrival order. No beat is dropped or duplicated.
- `sat_count` increments on an output transfer with `sat_flag` = 1 and sticks at 2^CNT_W-1.
  - `clr_stats` = 1 forces it to 0.
  - A clear on the same edge as an increment wins, giving 0.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `sat_count` = 0, s1 valid = 0. `in_ready` = 1 immediately after reset deasserts.
- Assertion of `reset` mid-operation discards all in-flight beats asynchronously. No partial beat is emitted after release.
- Latency is 2 cycles: with `out_ready` held at 1, a beat accepted at edge N is presented with `out_valid` = 1 after edge N+1 and transfers at edge N+2.
- Throughput is 1 beat/cycle when `out_ready` = 1 continuously.
- With `out_ready` = 0, at most 2 beats are held. `in_ready` falls once both stages are full.
- Simultaneous output transfer and input accept on one edge is legal and keeps full rate.

## Configuration
- `ACT_QUANT_ROUND_EN` defined: round-half-up before shifting (`rnd` as above).
- Undefined: truncation (`rnd` = 0).
- The ports, latency and handshake are identical in both builds.

## Structure
- Package `act_quant_pkg` holds:
  - the width constants `ACC_W`, `BIAS_W`, `SHIFT_W`, `OUT_W`, `CNT_W`;
  - `SUM_W` = 26;
  - `OUT_MAX` = 255;
  - the typedefs for the sum and output words.
- Sub-module `rshift_sat` is the combinational stage-2 datapath: r, shift -> `out_data`, `sat_flag`. The rounding macro is evaluated inside it.
- The top level owns the pipeline registers, handshake and counter.

## Test plan
- Basic: `in_acc`=150, bias=0, shift=0, `out_ready`=1 -> `out_data`=150 two edges after accept; `sat_count` stays 0.
- ReLU: `in_acc`=1000, bias=-2000, shift=0 -> `out_data`=0, no saturation. Also `in_acc`=0, bias=+40 -> 40.
- Saturation: `in_acc`=6000, bias=0, shift=4 (q=375) -> `out_data`=255, `sat_count`=1. Then pulse `clr_stats` on the same edge as a second saturating transfer -> `sat_count`=0.
- Rounding: `in_acc`=24, bias=0, shift=4 -> 2 with `ACT_QUANT_ROUND_EN`, 1 without. Also `in_acc`=23 -> 1 in both builds.
- Backpressure: send 5 back-to-back beats (values 10..14, shift=0) with `out_ready`=0 for 4 cycles, then 1.
  - `in_ready` drops after 2 accepts.
  - Outputs arrive as 10,11,12,13,14 with no loss, and `out_data` stays stable while stalled.
- Reset mid-flight: 2 beats in the pipeline, assert `reset`=0 between edges -> `out_valid` and `out_data` go to 0 at once. After release, no stale beat appears, and a new beat of 77 emerges with 2-cycle latency.
